hsv_hue_divider: RTL

Sequential back end of the colour-detect HSV path. Consumes the per-pixel dividend/delta/function/value tuple produced by `hsv_decoder` and turns it into a hue angle in whole degrees, 0..359. It uses a 6-iteration restoring divider. The V channel passes through, time-aligned with the hue. Its output feeds the colour-threshold comparator.

---
 rtl/hsv_hue_divider.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/hsv_hue_divider.sv
// Hue back end: turns the decoder's dividend/delta/function tuple into a hue in degrees 0..359.
// The HSV_HUE_ROUND_EN macro rounds the quotient to nearest; undefined, it truncates.
module hsv_hue_divider (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [8:0] i_dividend,
    input  logic [8:0] i_delta,
    input  logic [1:0] i_function,
    input  logic [8:0] i_hsv_value,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [8:0] o_hue,
    output logic [8:0] o_value,
    output logic       o_valid,
    output logic       o_overrun
);

    typedef enum logic [1:0] {StIdle, StDiv, StFin} state_e;

    state_e      state_q;
    logic        neg_q;
    logic [7:0]  base_q;
    logic [8:0]  value_q;
    logic [8:0]  divisor_q;
    logic [13:0] rem_q;
    logic [5:0]  quo_q;
    logic [2:0]  cnt_q;
    logic        ready_q;
    logic [8:0]  hue_q;
    logic [8:0]  out_value_q;
    logic        valid_q;
    logic        overrun_q;

    logic        accept;
    logic        chroma;
    logic [8:0]  abs_div;
    logic [13:0] rem_init;
    logic [2:0]  shamt;
    logic [13:0] shifted;
    logic        sub_ok;
    logic [5:0]  quo_clamped;
    logic [9:0]  hue_sum;
    logic [9:0]  hue_wrapped;
    logic [7:0]  base_sel;

    always_comb begin
        accept  = i_valid && ready_q;
        chroma  = (i_function != 2'd0) && (i_delta != 9'd0);
        // -256 maps to 256, which still fits the 9-bit unsigned magnitude.
        abs_div = i_dividend[8] ? (~i_dividend + 9'd1) : i_dividend;
`ifdef HSV_HUE_ROUND_EN
        rem_init = ({5'd0, abs_div} * 14'd60) + {6'd0, i_delta[8:1]};
`else
        rem_init = {5'd0, abs_div} * 14'd60;
`endif
        shamt   = 3'd5 - cnt_q;
        shifted = {5'd0, divisor_q} << shamt;
        sub_ok  = rem_q >= shifted;

        quo_clamped = (quo_q > 6'd60) ? 6'd60 : quo_q;
        hue_sum     = neg_q ? ({2'b00, base_q} - {4'b0000, quo_clamped})
                            : ({2'b00, base_q} + {4'b0000, quo_clamped});
        hue_wrapped = hue_sum[9] ? (hue_sum + 10'd360) : hue_sum;

        case (i_function)
            2'd2:    base_sel = 8'd120;
            2'd3:    base_sel = 8'd240;
            default: base_sel = 8'd0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= StIdle;
            neg_q       <= 1'b0;
            base_q      <= 8'd0;
            value_q     <= 9'd0;
            divisor_q   <= 9'd0;
            rem_q       <= 14'd0;
            quo_q       <= 6'd0;
            cnt_q       <= 3'd0;
            ready_q     <= 1'b1;
            hue_q       <= 9'd0;
            out_value_q <= 9'd0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            overrun_q <= i_valid && !ready_q;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        value_q <= i_hsv_value;
                        ready_q <= 1'b0;
                        quo_q   <= 6'd0;
                        cnt_q   <= 3'd0;
                        if (chroma) begin
                            neg_q     <= i_dividend[8];
                            base_q    <= base_sel;
                            divisor_q <= i_delta;
                            rem_q     <= rem_init;
                            state_q   <= StDiv;
                        end else begin
                            // Achromatic: hue is forced to 0 without running the divider.
                            neg_q     <= 1'b0;
                            base_q    <= 8'd0;
                            divisor_q <= 9'd0;
                            rem_q     <= 14'd0;
                            state_q   <= StFin;
                        end
                    end
                end
                StDiv: begin
                    if (sub_ok) begin
                        rem_q <= rem_q - shifted;
                    end
                    quo_q[shamt] <= sub_ok;
                    cnt_q        <= cnt_q + 3'd1;
                    if (cnt_q == 3'd5) begin
                        state_q <= StFin;
                    end
                end
                StFin: begin
                    valid_q     <= 1'b1;
                    hue_q       <= hue_wrapped[8:0];
                    out_value_q <= value_q;
                    ready_q     <= 1'b1;
                    state_q     <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready   = ready_q;
    assign o_hue     = hue_q;
    assign o_value   = out_value_q;
    assign o_valid   = valid_q;
    assign o_overrun = overrun_q;

endmodule
